// File: rtl/line_pkg.sv
// Shared types and constants for the line engine and its future siblings.
package line_pkg;

    // Default coordinate width; modules carry their own CW parameter.
    localparam int unsigned CW_DEFAULT = 11;

    // Extra bit on the error term so it can go negative without overflow.
    localparam int unsigned ERR_EXT = 1;

    typedef logic [CW_DEFAULT-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/line_drawer_pipe_if.sv
// Command-in / pixel-out stream bundle for the line engine.
interface line_drawer_pipe_if #(
    parameter int unsigned CW = 11
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] x0;
    logic [CW-1:0] y0;
    logic [CW-1:0] x1;
    logic [CW-1:0] y1;
    logic          abort;
    logic          pix_valid;
    logic          pix_ready;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          pix_last;
    logic          busy;
    logic          done;

    // Command source / pixel sink side.
    modport master (
        output cmd_valid, x0, y0, x1, y1, abort, pix_ready,
        input  cmd_ready, pix_valid, pix_x, pix_y, pix_last, busy, done
    );

    // Engine side.
    modport slave (
        input  cmd_valid, x0, y0, x1, y1, abort, pix_ready,
        output cmd_ready, pix_valid, pix_x, pix_y, pix_last, busy, done
    );
endinterface

// File: rtl/line_setup_calc.sv
// Combinational Bresenham setup: deltas, step directions, major/minor split.
module line_setup_calc
    import line_pkg::*;
#(
    parameter int unsigned CW = 11
) (
    input  logic [CW-1:0]                  x0_i,
    input  logic [CW-1:0]                  y0_i,
    input  logic [CW-1:0]                  x1_i,
    input  logic [CW-1:0]                  y1_i,
    output logic [CW-1:0]                  dx_o,
    output logic [CW-1:0]                  dy_o,
    output logic                           sx_neg_o,
    output logic                           sy_neg_o,
    output logic                           steep_o,
    output logic [CW-1:0]                  len_o,
    output logic [CW-1:0]                  minor_o,
    output logic signed [CW+ERR_EXT-1:0]   err_init_o
);

    // Absolute deltas with a sign flag per axis, then pick the major axis.
    always_comb begin
        sx_neg_o   = (x1_i < x0_i);
        sy_neg_o   = (y1_i < y0_i);
        dx_o       = sx_neg_o ? (x0_i - x1_i) : (x1_i - x0_i);
        dy_o       = sy_neg_o ? (y0_i - y1_i) : (y1_i - y0_i);
        steep_o    = (dy_o > dx_o);
        len_o      = steep_o ? dy_o : dx_o;
        minor_o    = steep_o ? dx_o : dy_o;
        err_init_o = signed'({{ERR_EXT{1'b0}}, len_o >> 1});
    end

endmodule

// File: rtl/line_drawer_pipe.sv
// Eight-octant Bresenham line engine, one pixel per cycle on a valid/ready stream.
module line_drawer_pipe
    import line_pkg::*;
#(
    parameter int unsigned CW        = 11,
    parameter bit          HOLD_LAST = 1'b1
) (
    input logic               clk,
    input logic               reset,
    line_drawer_pipe_if.slave bus
);

    localparam int unsigned   EW       = CW + ERR_EXT;
    localparam logic [CW-1:0] CoordOne = CW'(1);

    state_e                state_q, state_d;
    logic [CW-1:0]         x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [CW-1:0]         cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [CW-1:0]         rem_q, rem_d, len_q, len_d, minor_q, minor_d;
    logic signed [EW-1:0]  err_q, err_d;
    logic                  steep_q, steep_d, sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

    logic [CW-1:0]         calc_dx, calc_dy, calc_len, calc_minor;
    logic                  calc_sx_neg, calc_sy_neg, calc_steep;
    logic signed [EW-1:0]  calc_err;

    logic signed [EW-1:0]  err_t, len_s, minor_s;
    logic [CW-1:0]         step_x, step_y;

    line_setup_calc #(
        .CW (CW)
    ) u_setup (
        .x0_i       (x0_q),
        .y0_i       (y0_q),
        .x1_i       (x1_q),
        .y1_i       (y1_q),
        .dx_o       (calc_dx),
        .dy_o       (calc_dy),
        .sx_neg_o   (calc_sx_neg),
        .sy_neg_o   (calc_sy_neg),
        .steep_o    (calc_steep),
        .len_o      (calc_len),
        .minor_o    (calc_minor),
        .err_init_o (calc_err)
    );

    // Error update and unit steps along each axis for the current pixel.
    always_comb begin
        len_s   = signed'({{ERR_EXT{1'b0}}, len_q});
        minor_s = signed'({{ERR_EXT{1'b0}}, minor_q});
        err_t   = err_q - minor_s;
        step_x  = sx_neg_q ? (cur_x_q - CoordOne) : (cur_x_q + CoordOne);
        step_y  = sy_neg_q ? (cur_y_q - CoordOne) : (cur_y_q + CoordOne);
    end

    // Next-state: command latch, setup load, stepping, abort and completion.
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        rem_d    = rem_q;
        len_d    = len_q;
        minor_d  = minor_q;
        err_d    = err_q;
        steep_d  = steep_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        unique case (state_q)
            IDLE: begin
                // abort is meaningless here; a coincident command still wins.
                if (bus.cmd_valid) begin
                    x0_d    = bus.x0;
                    y0_d    = bus.y0;
                    x1_d    = bus.x1;
                    y1_d    = bus.y1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (bus.abort) begin
                    state_d = FIN;
                end else begin
                    len_d    = calc_len;
                    minor_d  = calc_minor;
                    err_d    = calc_err;
                    rem_d    = calc_len;
                    steep_d  = calc_steep;
                    sx_neg_d = calc_sx_neg;
                    sy_neg_d = calc_sy_neg;
                    cur_x_d  = x0_q;
                    cur_y_d  = y0_q;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                // Abort drops the pixel on offer even if the sink takes it.
                if (bus.abort) begin
                    state_d = FIN;
                end else if (bus.pix_ready) begin
                    if (rem_q == '0) begin
                        state_d = FIN;
                    end else begin
                        if (steep_q) begin
                            cur_y_d = step_y;
                        end else begin
                            cur_x_d = step_x;
                        end
                        if (err_t < 0) begin
                            if (steep_q) begin
                                cur_x_d = step_x;
                            end else begin
                                cur_y_d = step_y;
                            end
                            err_d = err_t + len_s;
                        end else begin
                            err_d = err_t;
                        end
                        rem_d = rem_q - CoordOne;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            rem_q    <= '0;
            len_q    <= '0;
            minor_q  <= '0;
            err_q    <= '0;
            steep_q  <= 1'b0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            rem_q    <= rem_d;
            len_q    <= len_d;
            minor_q  <= minor_d;
            err_q    <= err_d;
            steep_q  <= steep_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end

    // Outputs decode straight from state so done and pix_valid never overlap.
    always_comb begin
        bus.cmd_ready = (state_q == IDLE);
        bus.pix_valid = (state_q == DRAW);
        bus.pix_last  = HOLD_LAST && (state_q == DRAW) && (rem_q == '0);
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == FIN);
        bus.pix_x     = cur_x_q;
        bus.pix_y     = cur_y_q;
    end

    // The major/minor split handed over by the setup block must match its deltas.
    always_ff @(posedge clk) begin
        if (reset && state_q == SETUP) begin
            assert (calc_len == (calc_steep ? calc_dy : calc_dx) &&
                    calc_minor == (calc_steep ? calc_dx : calc_dy));
        end
    end

endmodule

// File: tb/tb_line_drawer_pipe.sv
// Directed bench for line_drawer_pipe: octants, degenerate, backpressure, abort, reset.
module tb_line_drawer_pipe;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    line_drawer_pipe_if #(.CW(11)) bus0 ();
    line_drawer_pipe_if #(.CW(16)) bus1 ();

    line_drawer_pipe #(.CW(11), .HOLD_LAST(1'b1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    line_drawer_pipe #(.CW(16), .HOLD_LAST(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int n_vec = 0;
    int n_bad = 0;

    int got_x[$];
    int got_y[$];
    int got_last[$];
    int hs_cyc[$];
    int done_cnt, done_cyc, first_valid_cyc, idle_cyc, overlap_cnt;
    int unstable_cnt, abort_cyc, valid_after_abort, timed_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command on bus0 and record every accepted pixel until idle again.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int rdy_mode, input int abort_after, input int max_cyc);
        int vcnt;
        logic stalled;
        int hold_x, hold_y;
        got_x.delete();
        got_y.delete();
        got_last.delete();
        hs_cyc.delete();
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; idle_cyc = -1;
        overlap_cnt = 0; unstable_cnt = 0; abort_cyc = -1; valid_after_abort = -1;
        timed_out = 1;
        vcnt = 0; stalled = 1'b0; hold_x = 0; hold_y = 0;
        bus0.x0 = 11'(ax0);
        bus0.y0 = 11'(ay0);
        bus0.x1 = 11'(ax1);
        bus0.y1 = 11'(ay1);
        bus0.cmd_valid = 1'b1;
        tick();
        bus0.cmd_valid = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            bus0.abort = 1'b0;
            if (abort_cyc >= 0 && c == abort_cyc + 1) valid_after_abort = int'(bus0.pix_valid);
            if (bus0.done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (bus0.done && bus0.pix_valid) overlap_cnt++;
            if (stalled && bus0.pix_valid &&
                (int'(bus0.pix_x) != hold_x || int'(bus0.pix_y) != hold_y)) unstable_cnt++;
            if (bus0.cmd_ready && done_cnt > 0) begin
                idle_cyc = c;
                timed_out = 0;
                break;
            end
            if (bus0.pix_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = c;
                bus0.pix_ready = (rdy_mode == 0) || (vcnt % 3 == 0);
                vcnt++;
                if (abort_after >= 0 && got_x.size() == abort_after && abort_cyc < 0) begin
                    bus0.abort = 1'b1;
                    bus0.pix_ready = 1'b1;
                    abort_cyc = c;
                end else if (bus0.pix_ready) begin
                    got_x.push_back(int'(bus0.pix_x));
                    got_y.push_back(int'(bus0.pix_y));
                    got_last.push_back(int'(bus0.pix_last));
                    hs_cyc.push_back(c);
                end
                stalled = !bus0.pix_ready;
                hold_x = int'(bus0.pix_x);
                hold_y = int'(bus0.pix_y);
            end else begin
                bus0.pix_ready = 1'b1;
                stalled = 1'b0;
            end
            tick();
        end
        bus0.abort = 1'b0;
        bus0.pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        reset = 1'b0;
        bus0.cmd_valid = 1'b0; bus0.abort = 1'b0; bus0.pix_ready = 1'b1;
        bus0.x0 = '0; bus0.y0 = '0; bus0.x1 = '0; bus0.y1 = '0;
        bus1.cmd_valid = 1'b0; bus1.abort = 1'b0; bus1.pix_ready = 1'b1;
        bus1.x0 = '0; bus1.y0 = '0; bus1.x1 = '0; bus1.y1 = '0;
        tick();
        tick();
        obs = {bus0.cmd_ready, bus0.pix_valid, bus0.pix_last, bus0.busy, bus0.done};
        n_vec++;
        if (obs !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 10000 (rdy,val,last,busy,done)", obs);
        end
        n_vec++;
        if (bus0.pix_x !== 11'd0 || bus0.pix_y !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", bus0.pix_x, bus0.pix_y);
        end
        obs = {bus1.cmd_ready, bus1.pix_valid, bus1.pix_last, bus1.busy, bus1.done};
        n_vec++;
        if (obs !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl16: got %b want 10000", obs);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_shallow();
        int ex[6] = '{0, 1, 2, 3, 4, 5};
        int ey[6] = '{0, 0, 1, 1, 2, 2};
        run_line(0, 0, 5, 2, 0, -1, 40);
        n_vec++;
        if (timed_out != 0 || got_x.size() != 6) begin
            n_bad++;
            $display("FAIL shallow_count: got %0d pixels (timeout=%0d) want 6", got_x.size(),
                     timed_out);
        end
        for (int i = 0; i < 6 && i < got_x.size(); i++) begin
            n_vec++;
            if (got_x[i] != ex[i] || got_y[i] != ey[i] || got_last[i] != (i == 5 ? 1 : 0)) begin
                n_bad++;
                $display("FAIL shallow_px%0d: got (%0d,%0d,last=%0d) want (%0d,%0d,last=%0d)",
                         i, got_x[i], got_y[i], got_last[i], ex[i], ey[i], (i == 5 ? 1 : 0));
            end
        end
        n_vec++;
        if (first_valid_cyc != 1) begin
            n_bad++;
            $display("FAIL shallow_latency: first valid %0d cycles after accept edge, want 1",
                     first_valid_cyc);
        end
        n_vec++;
        if (got_x.size() == 6 && (done_cnt != 1 || done_cyc != hs_cyc[5] + 1)) begin
            n_bad++;
            $display("FAIL shallow_done: got %0d pulses at cyc %0d want 1 at cyc %0d",
                     done_cnt, done_cyc, hs_cyc[5] + 1);
        end
        n_vec++;
        if (overlap_cnt != 0) begin
            n_bad++;
            $display("FAIL shallow_overlap: done with pix_valid %0d times want 0", overlap_cnt);
        end
    endtask

    task automatic test_steep();
        int ex[7] = '{10, 10, 9, 9, 9, 8, 8};
        int ey[7] = '{10, 9, 8, 7, 6, 5, 4};
        run_line(10, 10, 8, 4, 0, -1, 40);
        n_vec++;
        if (timed_out != 0 || got_x.size() != 7) begin
            n_bad++;
            $display("FAIL steep_count: got %0d pixels want 7", got_x.size());
        end
        for (int i = 0; i < 7 && i < got_x.size(); i++) begin
            n_vec++;
            if (got_x[i] != ex[i] || got_y[i] != ey[i] || got_last[i] != (i == 6 ? 1 : 0)) begin
                n_bad++;
                $display("FAIL steep_px%0d: got (%0d,%0d,last=%0d) want (%0d,%0d)",
                         i, got_x[i], got_y[i], got_last[i], ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_degenerate();
        run_line(3, 3, 3, 3, 0, -1, 20);
        n_vec++;
        if (got_x.size() != 1 || got_x[0] != 3 || got_y[0] != 3 || got_last[0] != 1) begin
            n_bad++;
            $display("FAIL degen_pixel: got %0d pixels first (%0d,%0d) want one (3,3) last",
                     got_x.size(), (got_x.size() > 0) ? got_x[0] : -1,
                     (got_y.size() > 0) ? got_y[0] : -1);
        end
        n_vec++;
        if (done_cnt != 1 || idle_cyc != 3) begin
            n_bad++;
            $display("FAIL degen_timing: got done=%0d ready at cyc %0d want 1 and 3",
                     done_cnt, idle_cyc);
        end
    endtask

    task automatic test_backpressure();
        run_line(0, 0, 4, 0, 1, -1, 60);
        n_vec++;
        if (timed_out != 0 || got_x.size() != 5) begin
            n_bad++;
            $display("FAIL bp_count: got %0d pixels want 5", got_x.size());
        end
        for (int i = 0; i < 5 && i < got_x.size(); i++) begin
            n_vec++;
            if (got_x[i] != i || got_y[i] != 0) begin
                n_bad++;
                $display("FAIL bp_px%0d: got (%0d,%0d) want (%0d,0)", i, got_x[i], got_y[i], i);
            end
        end
        n_vec++;
        if (unstable_cnt != 0) begin
            n_bad++;
            $display("FAIL bp_stable: pixel moved while stalled %0d times want 0", unstable_cnt);
        end
    endtask

    task automatic test_abort();
        run_line(0, 0, 100, 0, 0, 3, 60);
        n_vec++;
        if (timed_out != 0 || got_x.size() != 3 || got_x[2] != 2) begin
            n_bad++;
            $display("FAIL abort_count: got %0d pixels want 3 (0..2)", got_x.size());
        end
        n_vec++;
        if (valid_after_abort != 0) begin
            n_bad++;
            $display("FAIL abort_valid: got pix_valid=%0d after abort want 0", valid_after_abort);
        end
        n_vec++;
        if (done_cnt != 1 || done_cyc != abort_cyc + 1) begin
            n_bad++;
            $display("FAIL abort_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc,
                     abort_cyc + 1);
        end
        run_line(2, 1, 4, 1, 0, -1, 30);
        n_vec++;
        if (got_x.size() != 3 || got_x[0] != 2 || got_x[2] != 4 || got_y[2] != 1) begin
            n_bad++;
            $display("FAIL abort_next: got %0d pixels want (2,1)..(4,1)", got_x.size());
        end
    endtask

    task automatic test_reset_midline();
        logic [4:0] obs;
        int ex[4] = '{1, 2, 3, 4};
        int ey[4] = '{2, 2, 3, 3};
        bus0.x0 = 11'd0; bus0.y0 = 11'd0; bus0.x1 = 11'd20; bus0.y1 = 11'd5;
        bus0.pix_ready = 1'b1;
        bus0.cmd_valid = 1'b1;
        tick();
        bus0.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;
        tick();
        obs = {bus0.cmd_ready, bus0.pix_valid, bus0.pix_last, bus0.busy, bus0.done};
        n_vec++;
        if (obs !== 5'b10000 || bus0.pix_x !== 11'd0 || bus0.pix_y !== 11'd0) begin
            n_bad++;
            $display("FAIL midreset: got ctrl %b xy (%0d,%0d) want 10000 (0,0)", obs,
                     bus0.pix_x, bus0.pix_y);
        end
        reset = 1'b1;
        run_line(1, 2, 4, 3, 0, -1, 30);
        n_vec++;
        if (timed_out != 0 || got_x.size() != 4) begin
            n_bad++;
            $display("FAIL midreset_count: got %0d pixels want 4", got_x.size());
        end
        for (int i = 0; i < 4 && i < got_x.size(); i++) begin
            n_vec++;
            if (got_x[i] != ex[i] || got_y[i] != ey[i]) begin
                n_bad++;
                $display("FAIL midreset_px%0d: got (%0d,%0d) want (%0d,%0d)", i, got_x[i],
                         got_y[i], ex[i], ey[i]);
            end
        end
    endtask

    // Full-range anti-diagonal on the 16-bit instance: pixel k is (65535-k, k).
    task automatic test_wide();
        int k, bad, last_ok, done_seen;
        k = 0; bad = 0; last_ok = 0; done_seen = 0;
        bus1.x0 = 16'hFFFF; bus1.y0 = 16'h0000; bus1.x1 = 16'h0000; bus1.y1 = 16'hFFFF;
        bus1.pix_ready = 1'b1;
        bus1.cmd_valid = 1'b1;
        tick();
        bus1.cmd_valid = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            if (bus1.done) begin
                done_seen = 1;
                break;
            end
            if (bus1.pix_valid) begin
                if (int'(bus1.pix_x) != 65535 - k || int'(bus1.pix_y) != k ||
                    int'(bus1.pix_last) != (k == 65535 ? 1 : 0)) begin
                    if (bad < 3) $display("FAIL wide_px%0d: got (%0d,%0d,last=%0d)", k,
                                          bus1.pix_x, bus1.pix_y, bus1.pix_last);
                    bad++;
                end
                if (k == 65535 && bus1.pix_last) last_ok = 1;
                k++;
            end
            tick();
        end
        n_vec++;
        if (done_seen != 1 || k != 65536) begin
            n_bad++;
            $display("FAIL wide_count: got %0d pixels done=%0d want 65536 and 1", k, done_seen);
        end
        n_vec++;
        if (bad != 0 || last_ok != 1) begin
            n_bad++;
            $display("FAIL wide_path: got %0d bad pixels last_ok=%0d want 0 and 1", bad, last_ok);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_shallow();
        test_steep();
        test_degenerate();
        test_backpressure();
        test_abort();
        test_reset_midline();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/line_drawer_pipe.md
Name: line_drawer_pipe

Overview:
Parametrised successor to the current line-drawer control/datapath pair. It is a single self-contained Bresenham engine covering all eight octants, and it emits one pixel per cycle through a valid/ready stream with backpressure. Pixels are always emitted from (x0,y0) toward (x1,y1), using signed steps rather than endpoint swapping. It sits between the shape generator (command source) and the framebuffer writer (pixel sink).

Parameters:
CW, 11, coordinate width in bits (unsigned coordinates); internal error register is CW+1 bits signed.
HOLD_LAST, 1, 1 = pix_last asserts on the final pixel; 0 = pix_last tied low.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low (0 = reset)
cmd_valid  in  1  line command present
cmd_ready  out  1  engine can accept a command (high only in IDLE)
x0, y0, x1, y1  in  CW each  endpoints, sampled when cmd_valid && cmd_ready
abort  in  1  terminate the current line; takes effect next edge
pix_valid  out  1  pix_x/pix_y hold a valid pixel
pix_ready  in  1  sink accepts the pixel
pix_x, pix_y  out  CW each  pixel coordinate
pix_last  out  1  final pixel of the line (qualified by pix_valid)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after the final pixel handshake or after an abort

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, cmd_ready=1, pix_valid=0, pix_last=0, busy=0, done=0, pix_x=pix_y=0, error=0. Reset overrides everything, including mid-line.
- States: IDLE, SETUP, DRAW, FIN.
- IDLE: cmd_ready=1. On cmd_valid, latch endpoints and go to SETUP. No other state accepts commands.
- SETUP (1 cycle): compute the following, then go to DRAW with pix_valid=1.
  - dx=|x1-x0|, dy=|y1-y0|.
  - sx=+1 if x1>=x0 else -1; sy likewise.
  - steep=(dy>dx); L=max(dx,dy); m=min(dx,dy).
  - err=L>>1; remaining=L.
  - cur=(x0,y0).
- DRAW:
  - pix_x/pix_y = cur; pix_valid=1; pix_last = HOLD_LAST && remaining==0.
  - Handshake (pix_valid && pix_ready) with remaining!=0:
    - Step the major axis by its sign.
    - t = err - m. If t<0: step the minor axis by its sign and set err = t + L; else err = t.
    - remaining -= 1.
  - Handshake with remaining==0: go to FIN, pix_valid=0.
  - No handshake: cur, err and remaining hold. pix_x/pix_y must remain stable while pix_valid && !pix_ready.
- FIN (1 cycle): done=1, then go to IDLE. First command acceptance is possible the cycle after FIN.
- Latency and count:
  - Command accept to first pix_valid = 2 edges.
  - Exactly L+1 pixels are emitted; throughput is 1 pixel/cycle under continuous pix_ready.
  - The first pixel is (x0,y0) and the last is exactly (x1,y1).
- Degenerate line (x0==x1 && y0==y1): L=0; a single pixel with pix_last=1.
- Arithmetic: dx/dy are unsigned CW bits. err never leaves [-(m), L) before correction, so CW+1 signed bits are sufficient. Coordinates never wrap, because steps stop at the endpoint.
- abort:
  - In SETUP or DRAW: next state is FIN, pix_valid drops at that edge, and any pixel in flight is dropped even if pix_ready is high in the same cycle.
  - In IDLE or FIN: ignored.
- Simultaneous cmd_valid and abort in IDLE: command accepted, abort ignored.
- done and pix_valid are never high in the same cycle.

Decomposition:
- Package line_pkg:
  - typedef enum for the state {IDLE,SETUP,DRAW,FIN}.
  - parameterisable coordinate typedef via CW.
  - constant for the error width offset (+1).
- One natural sub-module: line_setup_calc. It is combinational and computes dx, dy, sx, sy, steep, L, m and err_init from the endpoints; it is reused by the future circle/polygon blocks.

Test Plan:
- Shallow, +x,+y: (0,0)->(5,2), pix_ready=1 -> pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2); pix_last on the 6th; done 1 cycle later; 6 pixels total.
- Steep, -x,-y: (10,10)->(8,4) -> 7 pixels; first (10,10), last (8,4); y decrements every pixel; x changes exactly twice.
- Degenerate: (3,3)->(3,3) -> one pixel (3,3) with pix_last=1, then done; cmd_ready returns 3 cycles after accept.
- Backpressure: (0,0)->(4,0) with pix_ready toggling 1,0,0,1,... -> pix_x/pix_y stable while stalled; still exactly 5 pixels, 0..4 in order.
- Abort: (0,0)->(100,0); assert abort after the 3rd handshake -> pix_valid low at the next edge; done pulses once; next command is accepted normally.
- Reset mid-line: drive reset=0 during DRAW -> all outputs at reset values the next cycle; a new command after release draws correctly. Also run CW=16 with endpoint (65535,0)->(0,65535): 65536 pixels, no wrap.
